// File: rtl/iterative_shift_sequencer.sv
// Multi-cycle variable shifter: coarse steps of S bits, then single-bit steps.
// One operation in flight; valid/ready on both request and result sides.
module iterative_shift_sequencer #(
  parameter int N  = 8,
  parameter int S  = 3,
  parameter int AW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  input  logic          in_arith,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COARSE = 2'd1,
    FINE   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [AW-1:0] NV  = AW'(N);
  localparam logic [AW-1:0] SV  = AW'(S);
  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [N-1:0]  out_q, out_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          dir_q, dir_d;
  logic          fill_q, fill_d;

  logic          accept;
  logic [AW-1:0] amt_c;
  logic [AW-1:0] rem_crs;
  logic [AW-1:0] rem_fin;
  logic [N-1:0]  crs_c;
  logic [N-1:0]  fin_c;

  assign accept  = in_valid & in_ready;
  assign amt_c   = (in_amt > NV) ? NV : in_amt;
  assign rem_crs = rem_q - SV;
  assign rem_fin = rem_q - ONE;

  // fill_q is the operand MSB only for arithmetic right shifts
  assign crs_c = dir_q ? {{S{fill_q}}, data_q[N-1:S]}
                       : {data_q[N-S-1:0], {S{1'b0}}};
  assign fin_c = dir_q ? {fill_q, data_q[N-1:1]}
                       : {data_q[N-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (amt_c >= SV)        state_d = COARSE;
          else if (amt_c != '0)   state_d = FINE;
          else                    state_d = DONE;
        end
      end
      COARSE: begin
        if (rem_crs >= SV)        state_d = COARSE;
        else if (rem_crs != '0)   state_d = FINE;
        else                      state_d = DONE;
      end
      FINE: begin
        if (rem_q == ONE)         state_d = DONE;
      end
      DONE: begin
        if (out_ready)            state_d = IDLE;
      end
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = out_q;
  end

  always_comb begin
    data_d = data_q;
    out_d  = out_q;
    rem_d  = rem_q;
    dir_d  = dir_q;
    fill_d = fill_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = in_data;
          rem_d  = amt_c;
          dir_d  = in_dir;
          fill_d = in_dir & in_arith & in_data[N-1];
          if (amt_c == '0) out_d = in_data;
        end
      end
      COARSE: begin
        data_d = crs_c;
        rem_d  = rem_crs;
        if (state_d == DONE) out_d = crs_c;
      end
      FINE: begin
        data_d = fin_c;
        rem_d  = rem_fin;
        if (state_d == DONE) out_d = fin_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      out_q  <= '0;
      rem_q  <= '0;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      data_q <= data_d;
      out_q  <= out_d;
      rem_q  <= rem_d;
      dir_q  <= dir_d;
      fill_q <= fill_d;
    end
  end

endmodule
